// File: rtl/vi_sync_sample_ctrl.sv
// vi_sync_sample_ctrl: destination-domain control for a one-stage stable-bus synchronizer.
// Synchronizes the request toggle, waits SETTLE_CYCLES for the source bus to settle,
// then issues a one-cycle sample strobe and returns an acknowledge toggle.
// Ports: clk, rst_n (async active-low), req_tgl (async toggle in), clr_err (sync clear);
//        sample (strobe), ack_tgl (registered toggle), busy, err_overrun (sticky), sample_cnt.
module vi_sync_sample_ctrl #(
  parameter int SYNC_STAGES   = 2,   // 2..4
  parameter int SETTLE_CYCLES = 2,   // 1..15
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_tgl,
  input  logic             clr_err,
  output logic             sample,
  output logic             ack_tgl,
  output logic             busy,
  output logic             err_overrun,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_d;
  logic                   req_edge;

  state_t                 state;
  state_t                 next_state;
  logic [3:0]             settle_cnt;
  logic [3:0]             next_settle_cnt;

  // Request synchronizer plus one extra flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      req_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
      req_d  <= req_s;
    end
  end

  assign req_s    = sync_q[SYNC_STAGES-1];
  assign req_edge = req_s ^ req_d;

  // State and settle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
    end else begin
      state      <= next_state;
      settle_cnt <= next_settle_cnt;
    end
  end

  // Edges outside IDLE are ignored here; they only raise err_overrun.
  always_comb begin
    next_state      = state;
    next_settle_cnt = settle_cnt;
    case (state)
      IDLE: begin
        if (req_edge) begin
          next_state      = SETTLE;
          next_settle_cnt = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          next_state = SAMPLE;
        end else begin
          next_settle_cnt = settle_cnt - 4'd1;
        end
      end
      SAMPLE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Decoded straight from the state so reset clears them without waiting for a clock.
  assign sample = (state == SAMPLE);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_tgl    <= 1'b0;
      sample_cnt <= '0;
    end else if (sample) begin
      ack_tgl    <= ~ack_tgl;
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  // Set takes priority over clear so a coincident overrun is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun <= 1'b0;
    end else if (req_edge && busy) begin
      err_overrun <= 1'b1;
    end else if (clr_err) begin
      err_overrun <= 1'b0;
    end
  end

endmodule

// File: doc/vi_sync_sample_ctrl.md
# vi_sync_sample_ctrl

Destination-domain control stage that generates the `sample` strobe for the downstream one-stage stable-bus synchronizer. It takes a request toggle from the source clock domain, synchronizes it, and waits a programmable settle interval so the source-held bus is stable. It then issues a single-cycle `sample` pulse and returns an acknowledge toggle to the source domain. It also flags protocol overruns and counts completed transfers.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `req_tgl`; legal range 2..4.
- `SETTLE_CYCLES`, 2: cycles from detected request edge to `sample`; legal range 1..15.
- `CNT_W`, 16: width of `sample_cnt`.

- `clk`  in  1  destination-domain clock; the only clock in the block.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_tgl`  in  1  request toggle from the source domain, asynchronous to `clk`; each transition is one request.
- `clr_err`  in  1  synchronous clear of `err_overrun`.
- `sample`  out  1  one-cycle strobe to the downstream synchronizer's `sample` input.
- `ack_tgl`  out  1  acknowledge toggle returned to the source domain, registered.
- `busy`  out  1  high while a request is in progress (SETTLE or SAMPLE).
- `err_overrun`  out  1  sticky: a request edge arrived while busy.
- `sample_cnt`  out  CNT_W  count of issued `sample` pulses; wraps.

## Operation
- Synchronizer:
  - `req_tgl` passes through a `SYNC_STAGES` flop chain; the last stage is `req_s`.
  - One further flop holds `req_d`.
  - `edge = req_s ^ req_d`, evaluated combinationally.
  - All chain flops and `req_d` reset to 0.
- FSM states are IDLE, SETTLE and SAMPLE. The state register resets to IDLE.
  - IDLE: on `edge`, go to SETTLE and load the settle counter with `SETTLE_CYCLES-1`.
  - SETTLE: decrement the counter each cycle. When the counter is 0, go to SAMPLE. The counter is 4 bits wide and never underflows.
  - SAMPLE: go to IDLE unconditionally. `ack_tgl` inverts on this clock edge.
- Output decode:
  - `sample = (state == SAMPLE)`.
  - `busy = (state != IDLE)`.
- `sample_cnt` increments by 1 on every SAMPLE cycle. It wraps from all-ones to 0.
- Overrun:
  - An `edge` while in SETTLE or SAMPLE sets `err_overrun` on the next edge.
  - The overrunning request is dropped: no extra `sample`, no extra `ack_tgl` flip.
  - `req_d` still follows `req_s`.
- `clr_err` clears `err_overrun`. If `clr_err` and a new overrun occur in the same cycle, set wins.
- An `edge` in the cycle the FSM is back in IDLE is accepted normally. Back-to-back requests are legal once `ack_tgl` has flipped.
- Reset mismatch with the source: if `req_tgl` is 1 at reset release, one transaction runs after `SYNC_STAGES` cycles. That transaction realigns `ack_tgl` to `req_tgl`. This is required behaviour, not an error.
- Reset mid-transfer: asynchronously return to IDLE and drive all outputs to 0. No partial `sample` is issued.

## Timing
- Reset values: `sample`=0, `ack_tgl`=0, `busy`=0, `err_overrun`=0, `sample_cnt`=0.
- Reference point: `req_tgl` transitions with setup met before clock edge 0.
  - `edge` is high in cycle `SYNC_STAGES`.
  - `busy` is high in cycles `SYNC_STAGES+1` through `SYNC_STAGES+SETTLE_CYCLES+1`.
  - `sample` is high exactly in cycle `SYNC_STAGES+SETTLE_CYCLES+1`.
  - The new `ack_tgl` value and the updated `sample_cnt` are visible from cycle `SYNC_STAGES+SETTLE_CYCLES+2`.
- `sample` is always exactly one cycle wide, with at most one pulse per accepted request.
- Source obligations:
  - Hold the data bus stable from before toggling `req_tgl` until the `ack_tgl` flip is seen.
  - Do not toggle `req_tgl` again before then.
- `SETTLE_CYCLES` ≥ 1 guarantees the bus has been stable for at least `SYNC_STAGES+1` destination cycles before `sample`. This satisfies the downstream two-cycle stability check.
- Minimum request spacing, measured at `edge`: `SETTLE_CYCLES+2` cycles.

## Test plan
- Reset, then hold `req_tgl`=0 for 50 cycles -> no `sample`; all outputs 0; `busy`=0.
- Defaults (2/2): toggle `req_tgl` 0->1 at edge 0 -> `busy` high in cycles 3..5; `sample` high only in cycle 5; `ack_tgl`=1 and `sample_cnt`=1 from cycle 6.
- Overrun: toggle `req_tgl` again at cycle 2 after the first toggle -> one `sample` only; `err_overrun`=1 and `ack_tgl`=1. Then assert `clr_err` in the same cycle as a fresh overrun -> `err_overrun` stays 1. Assert `clr_err` alone -> 0.
- Back-to-back: toggle `req_tgl` in the first cycle `ack_tgl` is seen flipped, repeat 1000 times with `CNT_W`=8 -> 1000 `sample` pulses; `sample_cnt`=232 (wrapped); `err_overrun`=0.
- Reset mismatch and mid-transfer reset:
  - Release reset with `req_tgl`=1 -> one `sample` at cycle `SYNC_STAGES+SETTLE_CYCLES+1`; `ack_tgl`=1.
  - Assert `rst_n` low during SETTLE -> all outputs 0 immediately; no `sample`.
- Parameter sweep: `SYNC_STAGES` in {2,4} × `SETTLE_CYCLES` in {1,15} -> `sample` at cycle `SYNC_STAGES+SETTLE_CYCLES+1` in each configuration.
